// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encoding and the default operand width live here.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, WIDTH+1 cycles start-to-done.
// Optional subtract mode (sub port, a - b) is built when SERIAL_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one operand bit pair through fa_cell per cycle
// DONE  | sum/cout just updated, done high; start here begins a new operation
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;
  logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so invert B once here and force the carry.
            a_sh  <= a;
            b_sh  <= sub_sel ? ~b : b;
            carry <= cin | sub_sel;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_next;
          acc   <= {s_bit, acc[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s_bit, acc[WIDTH-1:1]};
            cout  <= c_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8), directed plan steps plus random operations.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int nchecks = 0;
  int nerrs   = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic rs);
    int unsigned bv;
    int unsigned total;
    logic        s_on;
`ifdef SERIAL_ADDER_SUB_EN
    s_on = rs;
`else
    s_on = 1'b0;
`endif
    bv    = s_on ? ((2**W - 1) - int'(rb)) : int'(rb);
    total = int'(ra) + bv + ((rc || s_on) ? 1 : 0);
    return (W+1)'(total);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input bit scramble);
    logic [W:0] exp;
    exp = ref_model(ta, tb_v, tc, ts);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_first", busy, 1);
    check("done_first", done, 0);
    for (int i = 1; i < W; i++) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("sum_hold", sum, last_sum);
      check("cout_hold", cout, last_cout);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("sum", sum, exp[W-1:0]);
    check("cout", cout, exp[W]);
    last_sum  = exp[W-1:0];
    last_cout = exp[W];
    @(negedge clk);
    check("done_drop", done, 0);
    check("sum_after", sum, last_sum);
  endtask

  initial begin
    int n;
    int ndone;
    logic [W:0] e;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check("plan_ffff1", {cout, sum}, 9'h1FF);

    // start during RUN is ignored
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h55;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("ign_ndone", ndone, 1);
    check("ign_sum", sum, 8'h02);
    check("ign_cout", cout, 0);
    check("ign_idle", busy, 0);

    // reset in the 4th RUN cycle abandons the operation
    @(negedge clk);
    a = 8'hAA; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rrun_busy", busy, 0);
    check("rrun_done", done, 0);
    check("rrun_sum", sum, 0);
    check("rrun_cout", cout, 0);
    last_sum = '0; last_cout = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rrun_nodone", ndone, 0);
    run_op(8'h20, 8'h03, 1'b0, 1'b0, 1'b0);

    // back-to-back: start in DONE
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", done, 1);
    check("b2b_first_sum", sum, 8'h4C);
    a = 8'h10; b = 8'h10; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", n, 9);
    check("b2b_sum", sum, 8'h20);
    check("b2b_cout", cout, 0);
    last_sum = 8'h20; last_cout = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    check("sub_5m7", {cout, sum}, 9'h0FE);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
    check("sub_7m5", {cout, sum}, 9'h102);
`endif

    for (int k = 0; k < 30; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    // sanity on the model itself against a hand-derived value
    e = ref_model(8'h80, 8'h80, 1'b1, 1'b0);
    check("model_ref", e, 9'h101);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
